// File: rtl/seg7_scan_driver_if.sv
// Display-word inputs and scanned pin outputs between the MMIO register and the driver.
interface seg7_scan_driver_if;
    logic [31:0] SegData;
    logic [7:0]  DigitEn;
    logic        LzBlank;
    logic [7:0]  AnOut;
    logic [7:0]  SegOut;
    logic        FrameTick;

    // MMIO side: provides the display word, observes the pins
    modport master (
        output SegData,
        output DigitEn,
        output LzBlank,
        input  AnOut,
        input  SegOut,
        input  FrameTick
    );

    // Driver side: consumes the display word, drives the pins
    modport slave (
        input  SegData,
        input  DigitEn,
        input  LzBlank,
        output AnOut,
        output SegOut,
        output FrameTick
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Eight-digit hex seven-segment scan driver with per-frame shadow capture,
// per-slot dead time, digit masking and leading-zero suppression.
module seg7_scan_driver #(
    parameter int unsigned SCAN_DIV  = 100000,
    parameter int unsigned BLANK_CYC = 1000
) (
    input  logic               clk,
    input  logic               reset,
    seg7_scan_driver_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;
    logic [31:0]      sh_data;
    logic [7:0]       sh_en;
    logic             sh_lz;

    logic             slot_end;
    logic             in_blank;
    logic [2:0]       hi_idx;
    logic [7:0]       visible;
    logic [3:0]       nibble;

    logic [7:0]       an_d;
    logic [7:0]       seg_d;
    logic             tick_d;
    logic [7:0]       an_q;
    logic [7:0]       seg_q;
    logic             tick_q;

    // Hex nibble to gfedcba segment pattern
    function automatic logic [6:0] decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0:    s = 7'h3F;
            4'h1:    s = 7'h06;
            4'h2:    s = 7'h5B;
            4'h3:    s = 7'h4F;
            4'h4:    s = 7'h66;
            4'h5:    s = 7'h6D;
            4'h6:    s = 7'h7D;
            4'h7:    s = 7'h07;
            4'h8:    s = 7'h7F;
            4'h9:    s = 7'h6F;
            4'hA:    s = 7'h77;
            4'hB:    s = 7'h7C;
            4'hC:    s = 7'h39;
            4'hD:    s = 7'h5E;
            4'hE:    s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    assign slot_end = (cnt == CNT_LAST);
    assign in_blank = (32'(cnt) < BLANK_CYC);
    assign nibble   = sh_data[{idx, 2'b00} +: 4];

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: one LOAD cycle, then eight full slots of SCAN
    always_comb begin
        state_nxt = state;
        case (state)
            ST_LOAD: state_nxt = ST_SCAN;
            ST_SCAN: begin
                if (slot_end && (idx == 3'd7)) begin
                    state_nxt = ST_LOAD;
                end
            end
            default: state_nxt = ST_LOAD;
        endcase
    end

    // Slot counter, digit index and frame shadows
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            idx     <= 3'd0;
            sh_data <= 32'h0;
            sh_en   <= 8'h00;
            sh_lz   <= 1'b0;
        end else if (state == ST_LOAD) begin
            cnt     <= '0;
            idx     <= 3'd0;
            sh_data <= bus.SegData;
            sh_en   <= bus.DigitEn;
            sh_lz   <= bus.LzBlank;
        end else if (slot_end) begin
            cnt <= '0;
            if (idx != 3'd7) begin
                idx <= idx + 3'd1;
            end
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Per-digit visibility from the enable mask and the highest non-zero nibble
    always_comb begin
        hi_idx  = 3'd0;
        visible = 8'h00;
        for (int i = 1; i < 8; i++) begin
            if (sh_data[4*i +: 4] != 4'h0) begin
                hi_idx = 3'(i);
            end
        end
        for (int i = 0; i < 8; i++) begin
            visible[i] = sh_en[i] && (!sh_lz || (3'(i) <= hi_idx));
        end
    end

    // Output decode for the next registered pin values
    always_comb begin
        an_d   = 8'h00;
        seg_d  = 8'h00;
        tick_d = 1'b0;
        case (state)
            ST_LOAD: tick_d = 1'b1;
            ST_SCAN: begin
                if (!in_blank && visible[idx]) begin
                    an_d  = 8'h01 << idx;
                    seg_d = {1'b0, decode(nibble)};
                end
            end
            default: tick_d = 1'b0;
        endcase
    end

    // Pin registers; reset darkens the display immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an_q   <= 8'h00;
            seg_q  <= 8'h00;
            tick_q <= 1'b0;
        end else begin
            an_q   <= an_d;
            seg_q  <= seg_d;
            tick_q <= tick_d;
        end
    end

    assign bus.AnOut     = an_q;
    assign bus.SegOut    = seg_q;
    assign bus.FrameTick = tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench: a frame-level reference model predicts every registered
// output for two driver instances (SCAN_DIV=4/BLANK_CYC=1 and 2/0).
module tb_seg7_scan_driver;

    localparam int DA = 4;
    localparam int BA = 1;
    localparam int DB = 2;
    localparam int BB = 0;

    typedef struct packed {
        logic [7:0] an;
        logic [7:0] seg;
        logic       tick;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] seg_data = 32'h0;
    logic [7:0]  digit_en = 8'h00;
    logic        lz = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [6:0] seg_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    exp_t qa[$];
    exp_t qb[$];

    seg7_scan_driver_if bus_a ();
    seg7_scan_driver_if bus_b ();

    assign bus_a.SegData = seg_data;
    assign bus_a.DigitEn = digit_en;
    assign bus_a.LzBlank = lz;
    assign bus_b.SegData = seg_data;
    assign bus_b.DigitEn = digit_en;
    assign bus_b.LzBlank = lz;

    seg7_scan_driver #(.SCAN_DIV(DA), .BLANK_CYC(BA)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    seg7_scan_driver #(.SCAN_DIV(DB), .BLANK_CYC(BB)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    always #5 clk = ~clk;

    // Expected pins for an edge at position pos within a frame (0 = capture edge)
    function automatic exp_t model_out(int pos, int d, int b, logic [31:0] data,
                                       logic [7:0] en, logic lzb);
        exp_t e;
        int   slot;
        int   c;
        int   hi;
        logic [3:0] nib;
        e = '0;
        if (pos == 0) begin
            e.tick = 1'b1;
            return e;
        end
        slot = (pos - 1) / d;
        c    = (pos - 1) % d;
        hi   = 0;
        for (int i = 0; i < 8; i++) begin
            if (((data >> (4 * i)) & 32'hF) != 32'h0) hi = i;
        end
        nib = 4'((data >> (4 * slot)) & 32'hF);
        if ((c >= b) && en[slot] && (!lzb || slot <= hi)) begin
            e.an  = 8'(1 << slot);
            e.seg = {1'b0, seg_tbl[nib]};
        end
        return e;
    endfunction

    // Reference model: tracks frame position per instance and pushes expectations
    initial begin
        int k;
        logic [31:0] sd_a, sd_b;
        logic [7:0]  se_a, se_b;
        logic        sl_a, sl_b;
        int pa, pb;
        k = 0;
        sd_a = 0; sd_b = 0; se_a = 0; se_b = 0; sl_a = 0; sl_b = 0;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                k = 0;
                qa.delete();
                qb.delete();
            end else begin
                pa = k % (1 + 8 * DA);
                pb = k % (1 + 8 * DB);
                if (pa == 0) begin sd_a = seg_data; se_a = digit_en; sl_a = lz; end
                if (pb == 0) begin sd_b = seg_data; se_b = digit_en; sl_b = lz; end
                qa.push_back(model_out(pa, DA, BA, sd_a, se_a, sl_a));
                qb.push_back(model_out(pb, DB, BB, sd_b, se_b, sl_b));
                k++;
            end
        end
    end

    task automatic check_out(string nm, exp_t act, exp_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t actual an=%h seg=%h tick=%b required an=%h seg=%h tick=%b",
                     nm, $time, act.an, act.seg, act.tick, exp.an, exp.seg, exp.tick);
        end
    endtask

    // Monitor: pops one expectation per instance per cycle, mid-cycle
    initial begin
        exp_t act;
        exp_t exp;
        forever begin
            @(negedge clk);
            if (reset) begin
                check_out("a_reset", {bus_a.AnOut, bus_a.SegOut, bus_a.FrameTick}, '0);
                check_out("b_reset", {bus_b.AnOut, bus_b.SegOut, bus_b.FrameTick}, '0);
            end else begin
                act = {bus_a.AnOut, bus_a.SegOut, bus_a.FrameTick};
                if (qa.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL a_queue t=%0t actual empty required entry", $time);
                end else begin
                    exp = qa.pop_front();
                    check_out("a_out", act, exp);
                end
                act = {bus_b.AnOut, bus_b.SegOut, bus_b.FrameTick};
                if (qb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL b_queue t=%0t actual empty required entry", $time);
                end else begin
                    exp = qb.pop_front();
                    check_out("b_out", act, exp);
                end
            end
        end
    end

    task automatic cyc(int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    function automatic logic tick_of(int sel);
        return (sel == 0) ? bus_a.FrameTick : bus_b.FrameTick;
    endfunction

    // Wait (bounded) until the selected instance shows FrameTick
    task automatic wait_tick(int sel, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            if (tick_of(sel)) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL tick_timeout sel=%0d actual none required pulse", sel);
        end
    endtask

    // Count cycles between consecutive FrameTick pulses
    task automatic measure_period(int sel, int want);
        logic ok;
        int   n;
        wait_tick(sel, ok);
        if (ok) begin
            n = 0;
            for (int i = 0; i < 200; i++) begin
                @(negedge clk);
                #1;
                n++;
                if (tick_of(sel)) break;
            end
            checks++;
            if (n != want) begin
                errors++;
                $display("FAIL frame_period sel=%0d actual %0d required %0d", sel, n, want);
            end
        end
    endtask

    initial begin
        logic ok;
        reset    = 1'b1;
        seg_data = 32'h01ABCDEF;
        digit_en = 8'hFF;
        lz       = 1'b0;
        cyc(3);
        reset = 1'b0;
        cyc(70);
        measure_period(0, 1 + 8 * DA);
        measure_period(1, 1 + 8 * DB);

        lz = 1'b1; seg_data = 32'h00000120;
        cyc(70);
        seg_data = 32'h0;
        cyc(70);

        lz = 1'b0; digit_en = 8'h0F; seg_data = $urandom;
        cyc(70);

        digit_en = 8'hFF; seg_data = 32'h11111111;
        cyc(10);
        wait_tick(0, ok);
        if (ok) begin
            cyc(13);
            seg_data = 32'h22222222;
        end
        cyc(70);

        wait_tick(0, ok);
        if (ok) begin
            repeat (22) @(posedge clk);
            #2 reset = 1'b1;
            #1;
            check_out("a_async_dark", {bus_a.AnOut, bus_a.SegOut, bus_a.FrameTick}, '0);
            check_out("b_async_dark", {bus_b.AnOut, bus_b.SegOut, bus_b.FrameTick}, '0);
            cyc(2);
            reset = 1'b0;
        end
        cyc(70);

        for (int i = 0; i < 25; i++) begin
            seg_data = $urandom >> $urandom_range(0, 31);
            digit_en = 8'($urandom);
            lz       = 1'($urandom_range(0, 1));
            cyc($urandom_range(1, 40));
        end
        cyc(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Device-side consumer of the 32-bit seven-segment word that the MMIO block drives from CPU stores to 0xFFFF_FF14. The driver shows the word as eight hexadecimal digits by time-multiplexing one segment bus across eight digit anodes. It latches a shadow copy once per frame so that CPU writes never tear a frame, and it inserts a dead time between digits to suppress ghosting. It sits between the MMIO output register and the board's seven-segment pins.

## Interface
- SCAN_DIV, 100000: clock cycles per digit slot (1 ms at 100 MHz); legal range ≥ 2.
- BLANK_CYC, 1000: cycles at the start of each slot with anodes off; legal range 0 ≤ BLANK_CYC < SCAN_DIV.

- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  reset, asynchronous and active-high.
- SegData  in  32  display word from the MMIO seven-segment register; nibble i maps to digit i, with digit 0 rightmost.
- DigitEn  in  8  per-digit enable; a 0 forces that digit dark for the whole frame. Sampled at LOAD.
- LzBlank  in  1  leading-zero suppression enable. Sampled at LOAD.
- AnOut  out  8  anode select, active-high, one-hot or all-zero.
- SegOut  out  8  segments {dp,g,f,e,d,c,b,a}, active-high; dp is always 0.
- FrameTick  out  1  one-cycle pulse marking the edge on which a new shadow is captured.

## Operation
- **State machine**: two states, LOAD and SCAN. Reset enters LOAD.
  - **LOAD**, 1 cycle:
    - Captures SegData, DigitEn and LzBlank into shadow registers.
    - Clears the slot counter (cnt) and the digit index (idx).
    - Pulses FrameTick.
    - Drives AnOut=0 and SegOut=0.
    - Goes to SCAN.
  - **SCAN**:
    - cnt counts 0..SCAN_DIV-1.
    - At cnt=SCAN_DIV-1, cnt returns to 0 and idx increments.
    - At idx=7 with cnt=SCAN_DIV-1, the state returns to LOAD; idx does not wrap inside SCAN.
- **Decode** (hex nibble to gfedcba):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
- **Digit visibility**: digit i is visible only if all of the following hold.
  - DigitEn_shadow[i]=1.
  - LzBlank_shadow=0, or i ≤ the index of the highest non-zero nibble of the shadow.
  - Digit 0 is never suppressed by LzBlank, so an all-zero word shows "0".
- **Outputs during SCAN**:
  - While cnt < BLANK_CYC, or while digit idx is not visible: AnOut=0 and SegOut=0.
  - Otherwise: AnOut = 1<<idx and SegOut = decode(shadow[4*idx+3:4*idx]).
- **Shadow rule**: SegData, DigitEn and LzBlank changes have no visible effect until the next LOAD.
- **Output registers**: AnOut, SegOut and FrameTick are registered, with no combinational path from any input to any output.

## Timing
- **Reset values**: while reset is high, these hold immediately (asynchronous), not just at the next edge:
  - AnOut=8'h00, SegOut=8'h00, FrameTick=0
  - state=LOAD, cnt=0, idx=0
  - shadow=32'h0, DigitEn shadow=8'h00, LzBlank shadow=0
- **Edge numbering**: E0 is the first rising edge with reset low.
- **Capture**: at E0 the shadows capture the inputs. FrameTick is high from E0 to E1.
- **Digit slots**: digit i occupies the outputs registered at edges E(1+i·SCAN_DIV) through E(i·SCAN_DIV+SCAN_DIV).
  - The first BLANK_CYC of these edges produce dark outputs.
- **Frame period**: 1 + 8·SCAN_DIV cycles. The next LOAD edge is E(8·SCAN_DIV+1), and that cycle is dark.
- **Reset mid-frame**: outputs go dark immediately. On deassertion the driver restarts from LOAD with a fresh capture, with no partial-frame continuation.
- **Simultaneous input change and LOAD edge**: the value present at that edge is the one captured.

## Test plan
All scenarios use SCAN_DIV=4 and BLANK_CYC=1.
- **Basic scan**: reset, then SegData=32'h01ABCDEF, DigitEn=8'hFF, LzBlank=0.
  - Over slots 0..7, AnOut walks 01, 02, …, 80.
  - SegOut follows 71, 79, 5E, 39, 7C, 77, 06, 3F.
  - The first cycle of each slot is AnOut=0, SegOut=0.
  - FrameTick pulses at E0 and E33.
- **Leading-zero suppression**: LzBlank=1, SegData=32'h00000120.
  - Digits 0..2 show 3F, 5B, 06.
  - Slots 3..7 are fully dark.
  - SegData=0 shows only digit 0 = 3F.
- **DigitEn mask**: DigitEn=8'h0F with any SegData.
  - Slots 4..7 have AnOut=0 for all 4 cycles.
  - Slots 0..3 are unaffected.
- **Tear-free update**: change SegData from 32'h11111111 to 32'h22222222 during slot 3.
  - Slots 3..7 still show 06.
  - After the next FrameTick, all digits show 5B.
- **Async reset mid-slot**: assert reset between edges during slot 5.
  - AnOut and SegOut are 0 before the next edge.
  - After release, FrameTick pulses at E0 and slot 0 restarts at E1.
- **Parameter corner**: SCAN_DIV=2, BLANK_CYC=0.
  - Every slot lasts exactly 2 cycles with no dark cycle.
  - The frame is 17 cycles long.
